// File: rtl/jam_pkg.sv
// Shared types and constants for the 8x8 job-assignment solver.
// Holds the FSM state encoding, datapath widths and a popcount helper.
package jam_pkg;

  localparam int N     = 8;
  localparam int COSTW = 7;
  localparam int DPW   = 10;
  localparam int CNTW  = 4;
  localparam logic [DPW-1:0] INF = 10'd1023;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    LOAD = 2'd1,
    DP   = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) acc = acc + {3'b000, v[i]};
    return acc;
  endfunction

endpackage

// File: rtl/jam_if.sv
// Cost-ROM address/data bus plus the solver's result signals.
// The ROM answers one cycle after W/J are driven; results are level signals.
interface jam_if;
  import jam_pkg::*;

  logic [2:0]       W;
  logic [2:0]       J;
  logic [COSTW-1:0] Cost;
  logic [CNTW-1:0]  MatchCount;
  logic [8:0]       MinCost;
  logic             Valid;

  modport master (output W, J, MatchCount, MinCost, Valid, input Cost);
  modport slave  (input W, J, MatchCount, MinCost, Valid, output Cost);
endinterface

// File: rtl/jam_cost_table.sv
// 64x7 cost register file: one synchronous write port, one combinational read port.
// Read address is {worker, job}; no reset since every entry is written before use.
module jam_cost_table
  import jam_pkg::*;
(
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [5:0]       waddr_i,
  input  logic [COSTW-1:0] wdata_i,
  input  logic [2:0]       rw_i,
  input  logic [2:0]       rj_i,
  output logic [COSTW-1:0] rdata_o
);

  logic [COSTW-1:0] mem_q [64];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[{rw_i, rj_i}];

endmodule

// File: rtl/jam.sv
// Job-assignment solver: loads an 8x8 cost ROM, then runs a subset-bitmask DP.
// Valid rises 2106 cycles after reset release (1 init + 65 load + 2040 DP) and holds.
module jam
  import jam_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  jam_if.master       bus,
  output logic [1:0]  c_state,
  output logic [1:0]  n_state,
  output logic [5:0]  count,
  output logic [7:0]  mask_,
  output logic [7:0]  mask_next,
  output logic [9:0]  dp_new,
  output logic [9:0]  dp_mask,
  output logic [9:0]  dp_next_mask,
  output logic [9:0]  cost_table_number,
  output logic [3:0]  count_number,
  output logic [3:0]  mask_number,
  output logic [3:0]  n_mask_number
);

  state_e           state_q, state_d;
  logic [5:0]       count_q, count_d;
  logic [7:0]       m_q, m_d;
  logic             drain_q, drain_d;
  logic             ld_vld_q;
  logic [5:0]       ld_addr_q;
  logic [DPW-1:0]   dp_q  [256];
  logic [CNTW-1:0]  cnt_q [256];

  logic [2:0]       j;
  logic [7:0]       nm;
  logic [3:0]       w;
  logic [COSTW-1:0] cost_rd;
  logic [DPW-1:0]   cand;
  logic             expand, upd_lt, upd_eq;
  logic [CNTW-1:0]  cnt_new;
  logic             dbg;

  jam_cost_table u_cost (
    .clk_i   (CLK),
    .we_i    ((state_q == LOAD) && ld_vld_q),
    .waddr_i (ld_addr_q),
    .wdata_i (bus.Cost),
    .rw_i    (w[2:0]),
    .rj_i    (j),
    .rdata_o (cost_rd)
  );

  assign j       = count_q[2:0];
  assign nm      = m_q | (8'd1 << j);
  assign w       = popcnt8(m_q);
  assign cand    = dp_q[m_q] + {{(DPW-COSTW){1'b0}}, cost_rd};
  assign expand  = (state_q == DP) && !m_q[j];
  assign upd_lt  = expand && (cand < dp_q[nm]);
  assign upd_eq  = expand && (cand == dp_q[nm]);
  assign cnt_new = upd_lt ? cnt_q[m_q] : cnt_q[nm] + cnt_q[m_q];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    m_d     = m_q;
    drain_d = drain_q;
    unique case (state_q)
      INIT: begin
        state_d = LOAD;
        count_d = '0;
      end
      LOAD: begin
        // One extra drain cycle lets the last ROM word land in the table.
        if (drain_q) begin
          state_d = DP;
          count_d = '0;
          m_d     = '0;
          drain_d = 1'b0;
        end else begin
          count_d = count_q + 6'd1;
          if (count_q == 6'd63) drain_d = 1'b1;
        end
      end
      DP: begin
        if (j == 3'd7) begin
          count_d = '0;
          if (m_q == 8'd254) state_d = DONE;
          else               m_d     = m_q + 8'd1;
        end else begin
          count_d = count_q + 6'd1;
        end
      end
      DONE: ;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= INIT;
      count_q   <= '0;
      m_q       <= '0;
      drain_q   <= 1'b0;
      ld_vld_q  <= 1'b0;
      ld_addr_q <= '0;
      for (int k = 0; k < 256; k++) begin
        dp_q[k]  <= (k == 0) ? '0 : INF;
        cnt_q[k] <= (k == 0) ? CNTW'(1) : '0;
      end
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      m_q       <= m_d;
      drain_q   <= drain_d;
      ld_vld_q  <= (state_q == LOAD) && !drain_q;
      ld_addr_q <= count_q;
      if (upd_lt) dp_q[nm] <= cand;
      if (upd_lt || upd_eq) cnt_q[nm] <= cnt_new;
    end
  end

  assign bus.W          = (state_q == LOAD && !drain_q) ? count_q[5:3] : 3'd0;
  assign bus.J          = (state_q == LOAD && !drain_q) ? count_q[2:0] : 3'd0;
  assign bus.Valid      = (state_q == DONE);
  assign bus.MinCost    = (state_q == DONE) ? dp_q[255][8:0] : 9'd0;
  assign bus.MatchCount = (state_q == DONE) ? cnt_q[255] : '0;

  // Datapath debug taps only carry meaning while the DP sweep is running.
  assign dbg               = (state_q == DP);
  assign c_state           = state_q;
  assign n_state           = RST ? INIT : state_d;
  assign count             = count_q;
  assign mask_             = dbg ? m_q : '0;
  assign mask_next         = dbg ? nm : '0;
  assign dp_new            = dbg ? cand : '0;
  assign dp_mask           = dbg ? dp_q[m_q] : '0;
  assign dp_next_mask      = dbg ? dp_q[nm] : '0;
  assign cost_table_number = dbg ? {{(DPW-COSTW){1'b0}}, cost_rd} : '0;
  assign count_number      = dbg ? w : '0;
  assign mask_number       = dbg ? cnt_q[m_q] : '0;
  assign n_mask_number     = dbg ? cnt_q[nm] : '0;

endmodule

// File: tb/tb_jam.sv
// Directed bench for jam: a registered cost-ROM model, a table of cost patterns
// with hand-computed optimum/count, plus a mid-run reset sequence.
module tb_jam;
  import jam_pkg::*;

  logic       CLK;
  logic       RST;
  logic [1:0] c_state, n_state;
  logic [5:0] count;
  logic [7:0] mask_, mask_next;
  logic [9:0] dp_new, dp_mask, dp_next_mask, cost_table_number;
  logic [3:0] count_number, mask_number, n_mask_number;

  jam_if bus ();

  jam dut (
    .CLK               (CLK),
    .RST               (RST),
    .bus               (bus),
    .c_state           (c_state),
    .n_state           (n_state),
    .count             (count),
    .mask_             (mask_),
    .mask_next         (mask_next),
    .dp_new            (dp_new),
    .dp_mask           (dp_mask),
    .dp_next_mask      (dp_next_mask),
    .cost_table_number (cost_table_number),
    .count_number      (count_number),
    .mask_number       (mask_number),
    .n_mask_number     (n_mask_number)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  logic [6:0] rom [64];

  // ROM returns data for the address presented in the previous cycle.
  always @(posedge CLK) bus.Cost <= rom[{bus.W, bus.J}];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // 0 diagonal-zero, 1 all-5, 2 i+j, 3 two-way tie at 8, 4 all-127
  task automatic load_pattern(input int p);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) begin
        case (p)
          0: rom[i*8+k] = (i == k) ? 7'd0 : 7'd100;
          1: rom[i*8+k] = 7'd5;
          2: rom[i*8+k] = 7'(i + k);
          3: rom[i*8+k] = ((i == k) || (i == 0 && k == 1) || (i == 1 && k == 0)) ? 7'd1 : 7'd127;
          default: rom[i*8+k] = 7'd127;
        endcase
      end
    end
  endtask

  task automatic run_case(input int p, input logic [8:0] emin, input logic [3:0] ecnt,
                          input string nm);
    int   cyc;
    int   addr_err;
    bit   got;
    load_pattern(p);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk({nm, "_rst_valid"}, bus.Valid, 0);
    chk({nm, "_rst_state"}, c_state, INIT);
    chk({nm, "_rst_mincost"}, bus.MinCost, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk({nm, "_enter_load"}, c_state, LOAD);
    addr_err = 0;
    for (int k = 0; k < 64; k++) begin
      if ({bus.W, bus.J} !== 6'(k)) addr_err++;
      @(negedge CLK);
    end
    chk({nm, "_addr_seq_errors"}, addr_err, 0);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 3000) begin
      if (bus.Valid === 1'b1) got = 1'b1;
      else begin
        @(negedge CLK);
        cyc++;
      end
    end
    chk({nm, "_valid_seen"}, got, 1);
    chk({nm, "_latency"}, 65 + cyc, 2106);
    chk({nm, "_mincost"}, bus.MinCost, emin);
    chk({nm, "_matchcount"}, bus.MatchCount, ecnt);
    repeat (20) @(negedge CLK);
    chk({nm, "_valid_hold"}, bus.Valid, 1);
    chk({nm, "_mincost_hold"}, bus.MinCost, emin);
    chk({nm, "_wj_done"}, {bus.W, bus.J}, 0);
  endtask

  typedef struct {
    int         pat;
    logic [8:0] exp_min;
    logic [3:0] exp_cnt;
    string      name;
  } vec_t;

  vec_t vecs [5];

  initial begin
    RST = 1'b1;
    load_pattern(0);

    vecs[0] = '{0, 9'd0,  4'd1, "diag"};
    vecs[1] = '{1, 9'd40, 4'd0, "all5"};
    vecs[2] = '{2, 9'd56, 4'd0, "ipj"};
    vecs[3] = '{3, 9'd8,  4'd2, "tie2"};
    // 1016 does not fit the 9-bit port; only its low 9 bits (504) appear.
    vecs[4] = '{4, 9'(10'd1016), 4'd0, "all127"};

    for (int v = 0; v < 5; v++) begin
      run_case(vecs[v].pat, vecs[v].exp_min, vecs[v].exp_cnt, vecs[v].name);
    end

    // Abort a run in the middle of the DP sweep, then rerun the diagonal case.
    load_pattern(1);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (1000) @(negedge CLK);
    chk("midrun_in_dp", c_state, DP);
    RST = 1'b1;
    @(negedge CLK);
    chk("midrun_rst_state", c_state, INIT);
    chk("midrun_rst_valid", bus.Valid, 0);
    chk("midrun_rst_mask", mask_, 0);
    @(negedge CLK);
    RST = 1'b0;
    run_case(0, 9'd0, 4'd1, "rerun_diag");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
